instr_queue: RTL and testbench

- Instruction queue and decode stage at the front of the Tomasulo core.
- Accepts one raw RV32 word per cycle from fetch, decodes it into op class and register/immediate fields, and buffers decoded entries in a circular FIFO of IQ_SIZE entries.
- Presents the head entry to the issue/reservation-station stage with a valid/ready handshake.
- Drives IQ_FULL back to fetch as backpressure.

---
 rtl/instr_queue.sv | 129 ++++++++++++
 tb/tb_instr_queue.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/instr_queue.sv
// Instruction queue and decode stage: decodes raw RV32 words from fetch into op/reg/imm
// entries held in a circular FIFO, and presents the head entry to issue (FWFT).
module instr_queue #(
    parameter int DATAWIDTH = 32,
    parameter int IQ_SIZE   = 7,
    parameter int PTRW      = $clog2(IQ_SIZE),
    parameter int CNTW      = $clog2(IQ_SIZE + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [DATAWIDTH-1:0] instr,
    input  logic                 instr_valid,
    input  logic                 flush,
    input  logic                 iss_ready,
    output logic                 IQ_FULL,
    output logic [CNTW-1:0]      iq_count,
    output logic                 iq_valid,
    output logic [2:0]           iq_op,
    output logic [4:0]           iq_rd,
    output logic [4:0]           iq_rs1,
    output logic [4:0]           iq_rs2,
    output logic [11:0]          iq_imm,
    output logic                 illegal
);

    typedef enum logic [2:0] {
        OP_NONE = 3'd0, OP_ADD = 3'd1, OP_SUB = 3'd2,
        OP_MUL  = 3'd3, OP_DIV = 3'd4, OP_LW  = 3'd5
    } op_e;

    typedef struct packed {
        logic [2:0]  op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [11:0] imm;
    } entry_t;

    entry_t            mem_q [IQ_SIZE];
    logic [PTRW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTRW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CNTW-1:0]   count_q, count_d;
    logic              illegal_q, illegal_d;

    entry_t            dec;
    logic              dec_legal;
    logic              push, pop;
    entry_t            head;

    // Combinational decode of the offered word; only legal words reach the queue.
    always_comb begin
        dec       = '0;
        dec_legal = 1'b0;
        dec.rd    = instr[11:7];
        dec.rs1   = instr[19:15];
        dec.rs2   = instr[24:20];
        if (instr[6:0] == 7'b0110011) begin
            if (instr[14:12] == 3'b000) begin
                case (instr[31:25])
                    7'b0000000: begin dec.op = OP_ADD; dec_legal = 1'b1; end
                    7'b0100000: begin dec.op = OP_SUB; dec_legal = 1'b1; end
                    7'b0000001: begin dec.op = OP_MUL; dec_legal = 1'b1; end
                    default:    dec_legal = 1'b0;
                endcase
            end else if (instr[14:12] == 3'b100 && instr[31:25] == 7'b0000001) begin
                dec.op    = OP_DIV;
                dec_legal = 1'b1;
            end
        end else if (instr[6:0] == 7'b0000011 && instr[14:12] == 3'b010) begin
            dec.op    = OP_LW;
            dec.rs2   = '0;
            dec.imm   = instr[31:20];
            dec_legal = 1'b1;
        end
        if (!dec_legal) dec = '0;
    end

    // Push/pop qualify on registered count only, so an empty queue never pops a same-cycle push.
    assign push = instr_valid && dec_legal && (count_q < CNTW'(IQ_SIZE)) && !flush;
    assign pop  = iss_ready && (count_q != '0) && !flush;

    always_comb begin
        rd_ptr_d  = rd_ptr_q;
        wr_ptr_d  = wr_ptr_q;
        count_d   = count_q;
        illegal_d = instr_valid && !dec_legal && !flush;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = (wr_ptr_q == PTRW'(IQ_SIZE - 1)) ? '0 : wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_d = (rd_ptr_q == PTRW'(IQ_SIZE - 1)) ? '0 : rd_ptr_q + 1'b1;
            if (push && !pop)      count_d = count_q + 1'b1;
            else if (pop && !push) count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            count_q   <= '0;
            illegal_q <= 1'b0;
        end else begin
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            count_q   <= count_d;
            illegal_q <= illegal_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= dec;
    end

    // Storage is not reset, so the head is masked to zero while the queue is empty.
    assign head     = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
    assign iq_op    = head.op;
    assign iq_rd    = head.rd;
    assign iq_rs1   = head.rs1;
    assign iq_rs2   = head.rs2;
    assign iq_imm   = head.imm;
    assign iq_valid = (count_q != '0);
    assign IQ_FULL  = (count_q == CNTW'(IQ_SIZE));
    assign iq_count = count_q;
    assign illegal  = illegal_q;

endmodule

// File: tb/tb_instr_queue.sv
// Directed bench for instr_queue: a reference decode feeds a scoreboard queue of expected
// entries; every cycle the DUT head, flags and count are compared against it.
module tb_instr_queue;

    localparam int IQ = 7;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instr;
    logic        instr_valid, flush, iss_ready;
    logic        IQ_FULL, iq_valid, illegal;
    logic [2:0]  iq_count;
    logic [2:0]  iq_op;
    logic [4:0]  iq_rd, iq_rs1, iq_rs2;
    logic [11:0] iq_imm;

    int passed = 0;
    int total  = 0;
    logic [29:0] exp_q [$];
    logic        exp_ill = 1'b0;

    logic [31:0] prog [7] = '{32'h00012183, 32'h0241C133, 32'h026280B3, 32'h008381B3,
                              32'h023080B3, 32'h40508233, 32'h002200B3};

    instr_queue dut (
        .clk(clk), .reset(reset), .instr(instr), .instr_valid(instr_valid), .flush(flush),
        .iss_ready(iss_ready), .IQ_FULL(IQ_FULL), .iq_count(iq_count), .iq_valid(iq_valid),
        .iq_op(iq_op), .iq_rd(iq_rd), .iq_rs1(iq_rs1), .iq_rs2(iq_rs2), .iq_imm(iq_imm),
        .illegal(illegal)
    );

    always #5 clk = ~clk;

    // Reference decode: {legal, op, rd, rs1, rs2, imm}
    function automatic logic [30:0] ref_decode(input logic [31:0] w);
        logic [2:0] op;
        logic       ok;
        op = 3'd0;
        ok = 1'b0;
        if (w[6:0] == 7'h33 && w[14:12] == 3'd0 && w[31:25] == 7'h00) begin op = 3'd1; ok = 1'b1; end
        if (w[6:0] == 7'h33 && w[14:12] == 3'd0 && w[31:25] == 7'h20) begin op = 3'd2; ok = 1'b1; end
        if (w[6:0] == 7'h33 && w[14:12] == 3'd0 && w[31:25] == 7'h01) begin op = 3'd3; ok = 1'b1; end
        if (w[6:0] == 7'h33 && w[14:12] == 3'd4 && w[31:25] == 7'h01) begin op = 3'd4; ok = 1'b1; end
        if (w[6:0] == 7'h03 && w[14:12] == 3'd2) return {1'b1, 3'd5, w[11:7], w[19:15], 5'd0, w[31:20]};
        if (!ok) return '0;
        return {1'b1, op, w[11:7], w[19:15], w[24:20], 12'd0};
    endfunction

    function automatic logic [31:0] mk_add(input int k);
        logic [4:0] rd, rs1, rs2;
        rd  = 5'(k);
        rs1 = 5'(k + 7);
        rs2 = 5'(k + 13);
        return {7'd0, rs2, rs1, 3'd0, rd, 7'h33};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [29:0] head_vec();
        return {iq_op, iq_rd, iq_rs1, iq_rs2, iq_imm};
    endfunction

    task automatic check_state();
        int n;
        n = exp_q.size();
        chk("count", 32'(iq_count), 32'(n));
        chk("full", 32'(IQ_FULL), 32'(n == IQ));
        chk("valid", 32'(iq_valid), 32'(n != 0));
        chk("head", 32'(head_vec()), (n != 0) ? 32'(exp_q[0]) : 32'd0);
        chk("illegal", 32'(illegal), 32'(exp_ill));
    endtask

    // One clock: predict from current inputs, clock, then compare.
    task automatic tick();
        logic [30:0] d;
        logic        do_push, do_pop;
        d       = ref_decode(instr);
        do_push = instr_valid && d[30] && exp_q.size() < IQ && !flush;
        do_pop  = iss_ready && exp_q.size() > 0 && !flush;
        if (do_pop) chk("pop_head", 32'(head_vec()), 32'(exp_q[0]));
        @(posedge clk);
        #1;
        exp_ill = instr_valid && !d[30] && !flush;
        if (flush) exp_q.delete();
        else begin
            if (do_pop) void'(exp_q.pop_front());
            if (do_push) exp_q.push_back(d[29:0]);
        end
        check_state();
    endtask

    initial begin
        reset = 1'b0; instr = '0; instr_valid = 1'b0; flush = 1'b0; iss_ready = 1'b0;
        #2 check_state();
        #10 reset = 1'b1;
        @(posedge clk); #1;

        // Single LW push, visible one cycle later
        instr = prog[0]; instr_valid = 1'b1;
        tick();
        chk("lw_op", 32'(iq_op), 32'd5);
        chk("lw_rd", 32'(iq_rd), 32'd3);
        chk("lw_rs1", 32'(iq_rs1), 32'd2);
        chk("lw_rs2", 32'(iq_rs2), 32'd0);
        chk("lw_imm", 32'(iq_imm), 32'd0);
        chk("lw_cnt", 32'(iq_count), 32'd1);
        instr_valid = 1'b0; iss_ready = 1'b1;
        tick();

        // Fill to full, then offer an 8th word
        iss_ready = 1'b0;
        for (int i = 0; i < 7; i++) begin
            instr = prog[i]; instr_valid = 1'b1;
            tick();
        end
        chk("fill_full", 32'(IQ_FULL), 32'd1);
        chk("fill_cnt", 32'(iq_count), 32'd7);
        instr = 32'h00B50533;
        tick();
        chk("drop_cnt", 32'(iq_count), 32'd7);

        // Drain; first drain cycle still offers the 8th word while full
        iss_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            if (i == 1) begin
                chk("div_op", 32'(iq_op), 32'd4);
                chk("div_rd", 32'(iq_rd), 32'd2);
                chk("div_rs1", 32'(iq_rs1), 32'd3);
                chk("div_rs2", 32'(iq_rs2), 32'd4);
            end
            if (i == 5) begin
                chk("sub_op", 32'(iq_op), 32'd2);
                chk("sub_rd", 32'(iq_rd), 32'd4);
                chk("sub_rs1", 32'(iq_rs1), 32'd1);
                chk("sub_rs2", 32'(iq_rs2), 32'd5);
            end
            tick();
            instr_valid = 1'b0;
        end
        chk("drain_valid", 32'(iq_valid), 32'd0);
        chk("drain_head", 32'(head_vec()), 32'd0);

        // Wrap-around with steady occupancy of 3
        iss_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            instr = mk_add(k); instr_valid = 1'b1;
            tick();
        end
        iss_ready = 1'b1;
        for (int k = 3; k < 23; k++) begin
            instr = mk_add(k);
            tick();
            chk("wrap_cnt", 32'(iq_count), 32'd3);
        end
        instr_valid = 1'b0;
        for (int k = 0; k < 3; k++) tick();

        // Illegal word pulse, then a legal ADD
        iss_ready = 1'b0;
        instr = 32'h00000013; instr_valid = 1'b1;
        tick();
        chk("ill_pulse", 32'(illegal), 32'd1);
        chk("ill_cnt", 32'(iq_count), 32'd0);
        instr = mk_add(30);
        tick();
        chk("ill_end", 32'(illegal), 32'd0);
        chk("add_cnt", 32'(iq_count), 32'd1);

        // Grow to 4, then flush with push, pop and an illegal word all offered
        for (int k = 31; k < 34; k++) begin
            instr = mk_add(k);
            tick();
        end
        chk("pre_flush", 32'(iq_count), 32'd4);
        instr = 32'h00000013; flush = 1'b1; iss_ready = 1'b1;
        tick();
        chk("flush_cnt", 32'(iq_count), 32'd0);
        chk("flush_ill", 32'(illegal), 32'd0);
        flush = 1'b0; iss_ready = 1'b0;

        // Async reset mid-push
        instr = mk_add(40);
        tick();
        instr = mk_add(41);
        tick();
        #3 reset = 1'b0;
        #1;
        exp_q.delete();
        exp_ill = 1'b0;
        check_state();
        instr_valid = 1'b0;
        #2 reset = 1'b1;
        @(posedge clk); #1;
        check_state();
        instr = mk_add(42); instr_valid = 1'b1;
        tick();
        instr_valid = 1'b0; iss_ready = 1'b1;
        tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
